grf_bypass: RTL and testbench

Parametrised general register file for the pipelined CPU, successor to the single-cycle register file. Provides `NR` combinational read ports and one write port with optional write-to-read bypass, a hardwired zero register, and a per-register pending scoreboard. Decode uses the scoreboard to stall on outstanding writes; writeback uses the write port.

---
 rtl/grf_pkg.sv | 25 ++
 rtl/grf_scoreboard.sv | 48 ++++
 rtl/grf_bypass.sv | 68 ++++++
 tb/tb_grf_bypass.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared constants and helpers for the general register file.
package grf_pkg;

  localparam int DW_DEF   = 32;
  localparam int NREG_DEF = 32;
  localparam int NR_DEF   = 2;

  localparam int MAXW   = 16;
  localparam int MAXBUS = 4 * MAXW;

  // Extract field i of width w from a packed, zero-extended port bus.
  function automatic logic [MAXW-1:0] field(
    input logic [MAXBUS-1:0] bus,
    input int                i,
    input int                w
  );
    logic [MAXW-1:0] r;
    r = '0;
    for (int b = 0; b < MAXW; b++) begin
      if (b < w) r[b] = bus[i*w+b];
    end
    return r;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard: one bit per register plus a popcount counter.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  output logic [NREG-1:0] pending,
  output logic [AW:0]     pend_cnt
);

  logic            set_v;
  logic            clr_v;
  logic            inc;
  logic            dec;
  logic [NREG-1:0] nxt;

  assign set_v = set_en && (set_addr != '0);
  assign clr_v = clr_en && (clr_addr != '0);

  // A same-address set overrides the clear: a newer producer has issued.
  assign inc = set_v && !pending[set_addr];
  assign dec = clr_v && pending[clr_addr]
            && !(set_v && (set_addr == clr_addr));

  always_comb begin
    nxt = pending;
    if (clr_v) nxt[clr_addr] = 1'b0;
    if (set_v) nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= nxt;
      pend_cnt <= pend_cnt + (AW+1)'(inc) - (AW+1)'(dec);
    end
  end

endmodule

// File: rtl/grf_bypass.sv
// Multi-port register file with write bypass and pending scoreboard.
module grf_bypass
  import grf_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NR     = NR_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [DW-1:0]  wdata,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata,
  input  logic           set_en,
  input  logic [AW-1:0]  set_addr,
  output logic [NR-1:0]  busy,
  output logic [AW:0]    pend_cnt
);

  logic [DW-1:0]     regs [NREG];
  logic [NREG-1:0]   pending;
  logic [MAXBUS-1:0] rbus;

  assign rbus = MAXBUS'(raddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  grf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_addr (set_addr),
    .clr_en   (we),
    .clr_addr (waddr),
    .pending  (pending),
    .pend_cnt (pend_cnt)
  );

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;

    assign ra  = AW'(field(rbus, i, AW));
    assign hit = (BYPASS != 0) && we && (waddr == ra);

    always_comb begin
      rdata[i*DW +: DW] = regs[ra];
      if (ra == '0)  rdata[i*DW +: DW] = '0;
      else if (hit)  rdata[i*DW +: DW] = wdata;
    end

    assign busy[i] = pending[ra] && !hit;
  end

endmodule

// File: tb/tb_grf_bypass.sv
// Directed scoreboard bench for grf_bypass, with and without bypass.
module tb_grf_bypass;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic        set_en;
  logic [4:0]  set_addr;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  busy, busy_nb;
  logic [5:0]  pend_cnt, pend_cnt_nb;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  grf_bypass #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .set_en(set_en),
    .set_addr(set_addr), .busy(busy), .pend_cnt(pend_cnt)
  );

  grf_bypass #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_nb), .set_en(set_en),
    .set_addr(set_addr), .busy(busy_nb), .pend_cnt(pend_cnt_nb)
  );

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      unique case (e.sel)
        0: act = rdata[31:0];
        1: act = rdata[63:32];
        2: act = {30'd0, busy};
        3: act = {26'd0, pend_cnt};
        4: act = rdata_nb[31:0];
        default: act = {30'd0, busy_nb};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(input string n, input int s, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic drv(input logic r, input logic w, input logic [4:0] wa,
                     input logic [31:0] wd, input logic s,
                     input logic [4:0] sa, input logic [4:0] r0,
                     input logic [4:0] r1);
    rst = r; we = w; waddr = wa; wdata = wd;
    set_en = s; set_addr = sa; raddr = {r1, r0};
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    // reset overrides a write to r5
    drv(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 5, 0);
    expect_v("rst_r5", 0, 0);
    expect_v("rst_r0", 1, 0);
    expect_v("rst_cnt", 3, 0);
    expect_v("rst_busy", 2, 0);
    cyc();
    drv(0, 1, 3, 32'h12345678, 0, 0, 3, 0);
    expect_v("byp_r3", 0, 32'h12345678);
    expect_v("nobyp_r3", 4, 0);
    cyc();
    drv(0, 1, 0, 32'hFFFFFFFF, 0, 0, 3, 0);
    expect_v("rd_r3", 0, 32'h12345678);
    expect_v("rd_r0_wr", 1, 0);
    expect_v("nobyp_rd_r3", 4, 32'h12345678);
    cyc();
    drv(0, 0, 0, 0, 1, 9, 9, 0);
    expect_v("r0_after_wr", 1, 0);
    expect_v("set_same_cyc", 2, 0);
    expect_v("cnt0", 3, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 9, 9);
    expect_v("busy_r9", 2, 3);
    expect_v("cnt_r9", 3, 1);
    cyc();
    drv(0, 1, 9, 32'h11, 0, 0, 9, 9);
    expect_v("busy_clr_byp", 2, 0);
    expect_v("nobyp_busy", 5, 3);
    expect_v("cnt_pre_clr", 3, 1);
    cyc();
    drv(0, 1, 7, 32'hA5A5A5A5, 0, 0, 7, 9);
    expect_v("byp_r7", 0, 32'hA5A5A5A5);
    expect_v("nobyp_r7", 4, 0);
    expect_v("rd_r9", 1, 32'h11);
    expect_v("cnt_clr", 3, 0);
    expect_v("busy_clr", 2, 0);
    cyc();
    // collision on r4 while it is already pending
    drv(0, 0, 0, 0, 1, 4, 0, 0);
    cyc();
    drv(0, 1, 4, 32'hCAFEF00D, 1, 4, 4, 4);
    expect_v("col_cnt_pre", 3, 1);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 4, 4);
    expect_v("col_busy", 2, 3);
    expect_v("col_cnt", 3, 1);
    expect_v("col_data", 0, 32'hCAFEF00D);
    cyc();
    // set r10 and clear r4 together
    drv(0, 1, 4, 32'h1, 1, 10, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 4, 10);
    expect_v("diff_busy", 2, 2);
    expect_v("diff_cnt", 3, 1);
    cyc();
    drv(0, 1, 10, 32'h2, 1, 1, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 1, 2, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 1, 3, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 1, 3);
    expect_v("cnt3", 3, 3);
    expect_v("busy13", 2, 3);
    cyc();
    // reset mid-operation with an in-flight set and write
    drv(1, 1, 2, 32'h5, 1, 6, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 6, 2);
    expect_v("mrst_busy62", 2, 0);
    expect_v("mrst_cnt", 3, 0);
    expect_v("mrst_r2", 1, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 1, 3);
    expect_v("mrst_busy13", 2, 0);
    expect_v("mrst_r3", 1, 0);
    expect_v("nobyp_cnt", 3, 0);
    cyc();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
